matrix_disp_sched: RTL and testbench

Display scheduler for the 8x8 dot-matrix path: it shares the matrix between two requesters (A, B), queues their digit/colour requests in a 4-entry FIFO, and sequences each character for a fixed number of display ticks with an optional blank gap between characters. Outputs `idx` (character start address into the 8-row character ROM) and `sel` (green/red enable). These drive the row scanner and the colour gating directly, in place of the free-running index counter.

---
 rtl/matrix_disp_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_matrix_disp_sched.sv | 534 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_disp_sched.sv
// matrix_disp_sched: shares the 8x8 dot matrix between requesters A and B.
// Accepted characters are queued in a 4-entry FIFO. Each one is shown for
// HOLD_TICKS display ticks, followed by an optional blank gap of GAP_TICKS ticks.
module matrix_disp_sched #(
   parameter int unsigned HOLD_TICKS = 8,
   parameter int unsigned GAP_TICKS  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       a_valid,
   input  logic [3:0] a_digit,
   input  logic [1:0] a_color,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic [3:0] b_digit,
   input  logic [1:0] b_color,
   output logic       b_ready,
   output logic [6:0] idx,
   output logic [1:0] sel,
   output logic       owner,
   output logic       busy,
   output logic       done_a,
   output logic       done_b
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_e;

   typedef struct packed {
      logic       owner;
      logic [6:0] idx;
      logic [1:0] sel;
   } entry_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
   // When GAP_TICKS is 0 this value wraps, but GAP is then unreachable.
   localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);
   localparam bit         HAS_GAP   = (GAP_TICKS != 0);

   // Digits 0..9 start at row 8*(d+1); every other code shows the blank glyph at 0.
   function automatic logic [6:0] digit_to_idx(input logic [3:0] d);
      logic [3:0] d1;
      d1 = d + 4'd1;
      return (d <= 4'd9) ? {d1, 3'b000} : 7'd0;
   endfunction

   state_e     state_q, state_d;
   logic [7:0] tcnt_q, tcnt_d;
   logic [6:0] idx_q, idx_d;
   logic [1:0] sel_q, sel_d;
   logic       owner_q, owner_d;
   logic       busy_q, busy_d;
   logic       done_a_q, done_a_d;
   logic       done_b_q, done_b_d;
   logic       rr_q, rr_d;

   entry_t     mem_q [4];
   logic [1:0] wr_ptr_q, rd_ptr_q;
   logic [2:0] count_q;

   logic       full, empty;
   logic       push_a, push_b, push, pop;
   entry_t     push_entry, head;

   assign full    = (count_q == 3'd4);
   assign empty   = (count_q == 3'd0);
   assign a_ready = !full && (!b_valid || !rr_q);
   assign b_ready = !full && (!a_valid ||  rr_q);
   assign push_a  = a_valid && a_ready;
   assign push_b  = b_valid && b_ready;
   assign push    = push_a || push_b;
   assign head    = mem_q[rd_ptr_q];

   // A contested grant hands priority to the requester that lost.
   assign rr_d = (a_valid && b_valid && !full) ? !rr_q : rr_q;

   // Build the FIFO entry for the requester granted this cycle.
   always_comb begin
      push_entry.owner = 1'b0;
      push_entry.idx   = digit_to_idx(a_digit);
      push_entry.sel   = a_color;
      if (push_b) begin
         push_entry.owner = 1'b1;
         push_entry.idx   = digit_to_idx(b_digit);
         push_entry.sel   = b_color;
      end
   end

   // FIFO pointers, occupancy and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments, so every register samples start-of-cycle values.
      if (rst) begin
         rr_q     <= 1'b0;
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         rr_q <= rr_d;
         if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage array.
   always_ff @(posedge clk) begin
      // NOTE: the storage has no reset. An entry is only read while count_q says it is valid.
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   // Display sequencer: next state, pops and registered outputs.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a latch behind.
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      idx_d    = idx_q;
      sel_d    = sel_q;
      owner_d  = owner_q;
      done_a_d = 1'b0;
      done_b_d = 1'b0;
      pop      = 1'b0;

      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               idx_d   = head.idx;
               sel_d   = head.sel;
               owner_d = head.owner;
               tcnt_d  = 8'd0;
               state_d = SHOW;
            end
         end
         SHOW: begin
            if (tick) begin
               if (tcnt_q == HOLD_LAST) begin
                  done_a_d = !owner_q;
                  done_b_d =  owner_q;
                  tcnt_d   = 8'd0;
                  if (HAS_GAP) begin
                     idx_d   = 7'd0;
                     sel_d   = 2'b00;
                     state_d = GAP;
                  end else if (!empty) begin
                     pop     = 1'b1;
                     idx_d   = head.idx;
                     sel_d   = head.sel;
                     owner_d = head.owner;
                  end else begin
                     idx_d   = 7'd0;
                     sel_d   = 2'b00;
                     state_d = IDLE;
                  end
               end else begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (tcnt_q == GAP_LAST) begin
                  tcnt_d = 8'd0;
                  if (!empty) begin
                     pop     = 1'b1;
                     idx_d   = head.idx;
                     sel_d   = head.sel;
                     owner_d = head.owner;
                     state_d = SHOW;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tcnt_d  = 8'd0;
            idx_d   = 7'd0;
            sel_d   = 2'b00;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // Sequencer state and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         tcnt_q   <= 8'd0;
         idx_q    <= 7'd0;
         sel_q    <= 2'b00;
         owner_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_a_q <= 1'b0;
         done_b_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         idx_q    <= idx_d;
         sel_q    <= sel_d;
         owner_q  <= owner_d;
         busy_q   <= busy_d;
         done_a_q <= done_a_d;
         done_b_q <= done_b_d;
      end
   end

   assign idx    = idx_q;
   assign sel    = sel_q;
   assign owner  = owner_q;
   assign busy   = busy_q;
   assign done_a = done_a_q;
   assign done_b = done_b_q;

endmodule

// File: tb/tb_matrix_disp_sched.sv
// Testbench for matrix_disp_sched. dut_g uses the default gap of 2 ticks.
// dut_n has no gap and covers back-to-back display. Both DUTs share one stimulus.
module tb_matrix_disp_sched;

   typedef struct {
      bit       src;
      logic [3:0] digit;
      logic [1:0] color;
   } item_t;

   typedef struct {
      bit         owner;
      logic [6:0] idx;
      logic [1:0] sel;
   } rec_t;

   logic       clk, rst, tick;
   logic       a_valid, b_valid;
   logic [3:0] a_digit, b_digit;
   logic [1:0] a_color, b_color;

   logic       a_ready_g, b_ready_g, owner_g, busy_g, done_a_g, done_b_g;
   logic [6:0] idx_g;
   logic [1:0] sel_g;
   logic       a_ready_n, b_ready_n, owner_n, busy_n, done_a_n, done_b_n;
   logic [6:0] idx_n;
   logic [1:0] sel_n;

   int    n_cmp, n_err, done_cnt;
   int    tick_mode, tick_period, tick_ctr;
   bit    m_rr;
   item_t a_src[$], b_src[$], grant_q[$], exp_q[$];
   rec_t  obs_q[$];

   matrix_disp_sched #(.HOLD_TICKS(8), .GAP_TICKS(2)) dut_g (
      .clk(clk), .rst(rst), .tick(tick),
      .a_valid(a_valid), .a_digit(a_digit), .a_color(a_color), .a_ready(a_ready_g),
      .b_valid(b_valid), .b_digit(b_digit), .b_color(b_color), .b_ready(b_ready_g),
      .idx(idx_g), .sel(sel_g), .owner(owner_g), .busy(busy_g),
      .done_a(done_a_g), .done_b(done_b_g)
   );

   matrix_disp_sched #(.HOLD_TICKS(8), .GAP_TICKS(0)) dut_n (
      .clk(clk), .rst(rst), .tick(tick),
      .a_valid(a_valid), .a_digit(a_digit), .a_color(a_color), .a_ready(a_ready_n),
      .b_valid(b_valid), .b_digit(b_digit), .b_color(b_color), .b_ready(b_ready_n),
      .idx(idx_n), .sel(sel_n), .owner(owner_n), .busy(busy_n),
      .done_a(done_a_n), .done_b(done_b_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Display-rate strobe: off, every tick_period clocks, or random.
   initial begin
      tick = 1'b0;
      tick_ctr = 0;
      forever begin
         @(posedge clk);
         #1;
         tick_ctr++;
         if (tick_mode == 0)      tick = 1'b0;
         else if (tick_mode == 1) tick = ((tick_ctr % tick_period) == 0);
         else                     tick = ($urandom_range(0, 2) == 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   // Record each finished character of dut_g: the value shown just before the done pulse.
   logic [6:0] p_idx;
   logic [1:0] p_sel;
   logic       p_owner;
   initial begin
      p_idx = 7'd0; p_sel = 2'b00; p_owner = 1'b0;
   end
   always @(negedge clk) begin
      if (done_a_g || done_b_g) begin
         n_cmp++;
         if ((done_a_g && done_b_g) || (p_owner !== done_b_g)) begin
            n_err++;
            $display("FAIL done_owner: got done_a=%b done_b=%b, required one pulse for owner %b",
                     done_a_g, done_b_g, p_owner);
         end
         obs_q.push_back('{owner: done_b_g, idx: p_idx, sel: p_sel});
         done_cnt++;
      end
      p_idx   = idx_g;
      p_sel   = sel_g;
      p_owner = owner_g;
   end

   // Address mapping taken directly from the character ROM layout.
   function automatic logic [6:0] exp_idx(input logic [3:0] d);
      int v;
      v = (int'(d) < 10) ? 8 * (int'(d) + 1) : 0;
      return 7'(v);
   endfunction

   function automatic item_t mk(input bit src, input int digit, input int color);
      item_t it;
      it.src   = src;
      it.digit = 4'(digit);
      it.color = 2'(color);
      return it;
   endfunction

   task automatic do_reset();
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_rr = 1'b0;
      obs_q.delete();
      grant_q.delete();
      done_cnt = 0;
   endtask

   // Offer the queued items of both requesters. Each item is held until a handshake.
   // Contested winners are checked against the round-robin model.
   task automatic drive_streams(input bit rnd_valid, input int budget, input string tag);
      int cyc;
      bit acc_a, acc_b;
      cyc = 0;
      while ((a_src.size() > 0 || b_src.size() > 0) && cyc < budget) begin
         a_valid = (a_src.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
         b_valid = (b_src.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
         if (a_src.size() > 0) begin a_digit = a_src[0].digit; a_color = a_src[0].color; end
         if (b_src.size() > 0) begin b_digit = b_src[0].digit; b_color = b_src[0].color; end
         @(negedge clk);
         acc_a = a_valid && a_ready_g;
         acc_b = b_valid && b_ready_g;
         if (a_valid && b_valid) begin
            n_cmp++;
            if (acc_a && acc_b) begin
               n_err++;
               $display("FAIL %s_double_grant: got both ready, required at most one", tag);
            end else if ((acc_a || acc_b) && (acc_b !== m_rr)) begin
               n_err++;
               $display("FAIL %s_rr_winner: got grant to %s, required %s", tag,
                        acc_b ? "B" : "A", m_rr ? "B" : "A");
            end
            if (acc_a || acc_b) m_rr = !m_rr;
         end
         if (acc_a) grant_q.push_back(a_src.pop_front());
         if (acc_b) grant_q.push_back(b_src.pop_front());
         @(posedge clk);
         #1;
         cyc++;
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      if (a_src.size() > 0 || b_src.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_accept_timeout: got %0d items still pending, required 0", tag,
                  a_src.size() + b_src.size());
         a_src.delete();
         b_src.delete();
      end
   endtask

   task automatic wait_dones(input int n, input string tag);
      int cyc;
      cyc = 0;
      while (done_cnt < n && cyc < 20000) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      if (done_cnt < n) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_done_timeout: got %0d done pulses, required %0d", tag, done_cnt, n);
      end
      @(posedge clk);
      #1;
   endtask

   // Compare recorded characters with exp_q. The display must follow acceptance order.
   task automatic scoreboard_drain(input string tag);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL %s_count: got %0d characters, required %0d", tag, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i].owner !== exp_q[i].src || obs_q[i].idx !== exp_idx(exp_q[i].digit) ||
             obs_q[i].sel !== exp_q[i].color) begin
            n_err++;
            $display("FAIL %s_char%0d: got owner=%b idx=%0d sel=%b, required owner=%b idx=%0d sel=%b",
                     tag, i, obs_q[i].owner, obs_q[i].idx, obs_q[i].sel,
                     exp_q[i].src, exp_idx(exp_q[i].digit), exp_q[i].color);
         end
      end
   endtask

   // Count ticks while the chosen DUT keeps showing (w_idx, w_sel, w_busy).
   // Call at a negedge; the task returns at the first negedge where the value changes.
   task automatic count_ticks(input bit use_n, input logic [6:0] w_idx, input logic [1:0] w_sel,
                              input logic w_busy, output int ticks);
      int cyc;
      cyc = 0;
      ticks = 0;
      while (cyc < 4000) begin
         if (use_n) begin
            if (!(idx_n === w_idx && sel_n === w_sel && busy_n === w_busy)) break;
         end else begin
            if (!(idx_g === w_idx && sel_g === w_sel && busy_g === w_busy)) break;
         end
         if (tick) ticks++;
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 4000) ticks = -1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({idx_g, sel_g, owner_g, busy_g, done_a_g, done_b_g} !== 13'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got idx=%0d sel=%b owner=%b busy=%b done=%b%b, required all 0",
                  idx_g, sel_g, owner_g, busy_g, done_a_g, done_b_g);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({a_ready_g, b_ready_g, a_ready_n, b_ready_n} !== 4'b1111) begin
         n_err++;
         $display("FAIL reset_ready: got %b%b%b%b, required 1111", a_ready_g, b_ready_g, a_ready_n, b_ready_n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      int t;
      do_reset();
      tick_mode = 1;
      tick_period = 4;
      a_digit = 4'd3;
      a_color = 2'b01;
      a_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (a_ready_g !== 1'b1) begin
         n_err++;
         $display("FAIL t1_ready: got a_ready=%b, required 1", a_ready_g);
      end
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy_g !== 1'b0 || idx_g !== 7'd0) begin
         n_err++;
         $display("FAIL t1_latency: got busy=%b idx=%0d one edge after accept, required 0/0", busy_g, idx_g);
      end
      @(negedge clk);
      n_cmp++;
      if ({idx_g, sel_g, owner_g, busy_g} !== {7'd32, 2'b01, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL t1_load: got idx=%0d sel=%b owner=%b busy=%b, required 32/01/0/1",
                  idx_g, sel_g, owner_g, busy_g);
      end
      count_ticks(1'b0, 7'd32, 2'b01, 1'b1, t);
      n_cmp++;
      if (t != 8) begin
         n_err++;
         $display("FAIL t1_hold: got %0d ticks, required 8", t);
      end
      n_cmp++;
      if ({done_a_g, done_b_g, idx_g, sel_g, busy_g} !== {1'b1, 1'b0, 7'd0, 2'b00, 1'b1}) begin
         n_err++;
         $display("FAIL t1_gap_entry: got done=%b%b idx=%0d sel=%b busy=%b, required 10/0/00/1",
                  done_a_g, done_b_g, idx_g, sel_g, busy_g);
      end
      count_ticks(1'b0, 7'd0, 2'b00, 1'b1, t);
      n_cmp++;
      if (t != 2) begin
         n_err++;
         $display("FAIL t1_gap: got %0d gap ticks, required 2", t);
      end
      n_cmp++;
      if (busy_g !== 1'b0 || idx_g !== 7'd0) begin
         n_err++;
         $display("FAIL t1_idle: got busy=%b idx=%0d, required 0/0", busy_g, idx_g);
      end
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (done_cnt != 1) begin
         n_err++;
         $display("FAIL t1_done_count: got %0d pulses, required 1", done_cnt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_arbitration();
      do_reset();
      tick_mode = 1;
      tick_period = 1;
      a_src = '{mk(0, 0, 1), mk(0, 1, 2)};
      b_src = '{mk(1, 5, 3), mk(1, 6, 0)};
      exp_q = '{mk(0, 0, 1), mk(1, 5, 3), mk(0, 1, 2), mk(1, 6, 0)};
      drive_streams(1'b0, 50, "t2");
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= grant_q.size() || grant_q[i].src !== exp_q[i].src || grant_q[i].digit !== exp_q[i].digit) begin
            n_err++;
            $display("FAIL t2_grant%0d: got %s, required src=%b digit=%0d", i,
                     (i >= grant_q.size()) ? "nothing" : "other", exp_q[i].src, exp_q[i].digit);
         end
      end
      wait_dones(4, "t2");
      scoreboard_drain("t2");
   endtask

   task automatic test_fifo_full();
      int stall;
      bit accepted;
      do_reset();
      tick_mode = 1;
      tick_period = 4;
      for (int i = 0; i < 5; i++) a_src.push_back(mk(0, i, 1));
      exp_q = a_src;
      exp_q.push_back(mk(0, 7, 2));
      drive_streams(1'b0, 50, "t3");
      a_digit = 4'd7;
      a_color = 2'b10;
      a_valid = 1'b1;
      stall = 0;
      accepted = 1'b0;
      for (int c = 0; c < 2000 && !accepted; c++) begin
         @(negedge clk);
         if (a_ready_g) begin
            accepted = 1'b1;
            n_cmp++;
            if (idx_g !== exp_idx(4'd1) || p_idx === exp_idx(4'd1)) begin
               n_err++;
               $display("FAIL t3_release: got accept with idx=%0d prev=%0d, required first cycle of idx=%0d",
                        idx_g, p_idx, exp_idx(4'd1));
            end
         end else begin
            stall++;
         end
         @(posedge clk);
         #1;
      end
      a_valid = 1'b0;
      n_cmp++;
      if (!accepted || stall == 0) begin
         n_err++;
         $display("FAIL t3_hold: got accepted=%b after %0d stall cycles, required accepted after >0 stalls",
                  accepted, stall);
      end
      wait_dones(6, "t3");
      scoreboard_drain("t3");
   endtask

   task automatic test_back_to_back();
      int t, c;
      do_reset();
      tick_mode = 1;
      tick_period = 2;
      a_src = '{mk(0, 9, 1), mk(0, 2, 2)};
      drive_streams(1'b0, 50, "t4");
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (idx_n !== 7'd80 && c < 200);
      n_cmp++;
      if (idx_n !== 7'd80) begin
         n_err++;
         $display("FAIL t4_first: got idx=%0d, required 80", idx_n);
      end
      count_ticks(1'b1, 7'd80, 2'b01, 1'b1, t);
      n_cmp++;
      if (t != 8) begin
         n_err++;
         $display("FAIL t4_hold9: got %0d ticks, required 8", t);
      end
      n_cmp++;
      if ({idx_n, sel_n, done_a_n, busy_n} !== {7'd24, 2'b10, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL t4_switch: got idx=%0d sel=%b done_a=%b busy=%b, required 24/10/1/1",
                  idx_n, sel_n, done_a_n, busy_n);
      end
      count_ticks(1'b1, 7'd24, 2'b10, 1'b1, t);
      n_cmp++;
      if (t != 8) begin
         n_err++;
         $display("FAIL t4_hold2: got %0d ticks, required 8", t);
      end
      n_cmp++;
      if ({idx_n, busy_n, done_a_n} !== {7'd0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL t4_idle: got idx=%0d busy=%b done_a=%b, required 0/0/1", idx_n, busy_n, done_a_n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_blank_code();
      int t;
      do_reset();
      tick_mode = 1;
      tick_period = 2;
      a_src = '{mk(0, 12, 3)};
      drive_streams(1'b0, 20, "t5");
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({idx_g, sel_g, busy_g} !== {7'd0, 2'b11, 1'b1}) begin
         n_err++;
         $display("FAIL t5_load: got idx=%0d sel=%b busy=%b, required 0/11/1", idx_g, sel_g, busy_g);
      end
      count_ticks(1'b0, 7'd0, 2'b11, 1'b1, t);
      n_cmp++;
      if (t != 8) begin
         n_err++;
         $display("FAIL t5_hold: got %0d ticks, required 8", t);
      end
      n_cmp++;
      if ({done_a_g, sel_g, busy_g} !== {1'b1, 2'b00, 1'b1}) begin
         n_err++;
         $display("FAIL t5_done: got done_a=%b sel=%b busy=%b, required 1/00/1", done_a_g, sel_g, busy_g);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      do_reset();
      tick_mode = 2;
      for (int i = 0; i < 16; i++) begin
         a_src.push_back(mk(0, $urandom_range(0, 15), $urandom_range(0, 3)));
         b_src.push_back(mk(1, $urandom_range(0, 15), $urandom_range(0, 3)));
      end
      drive_streams(1'b1, 20000, "rnd");
      exp_q = grant_q;
      wait_dones(32, "rnd");
      scoreboard_drain("rnd");
   endtask

   task automatic test_reset_mid_show();
      int busy_seen;
      do_reset();
      tick_mode = 1;
      tick_period = 4;
      b_src = '{mk(1, 4, 2)};
      drive_streams(1'b0, 50, "t6");
      a_src = '{mk(0, 1, 1), mk(0, 2, 1)};
      drive_streams(1'b0, 50, "t6");
      repeat (6) @(negedge clk);
      n_cmp++;
      if ({idx_g, owner_g, busy_g} !== {7'd40, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL t6_pre: got idx=%0d owner=%b busy=%b, required 40/1/1", idx_g, owner_g, busy_g);
      end
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({idx_g, sel_g, owner_g, busy_g, done_a_g, done_b_g} !== 13'd0) begin
         n_err++;
         $display("FAIL t6_async: got idx=%0d sel=%b owner=%b busy=%b done=%b%b, required all 0 before edge",
                  idx_g, sel_g, owner_g, busy_g, done_a_g, done_b_g);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_rr = 1'b0;
      tick_period = 1;
      @(negedge clk);
      n_cmp++;
      if ({a_ready_g, b_ready_g} !== 2'b11) begin
         n_err++;
         $display("FAIL t6_ready: got %b%b, required 11", a_ready_g, b_ready_g);
      end
      busy_seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (busy_g) busy_seen++;
      end
      n_cmp++;
      if (busy_seen != 0) begin
         n_err++;
         $display("FAIL t6_fifo_empty: got %0d busy cycles after reset, required 0", busy_seen);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      done_cnt = 0;
      m_rr = 1'b0;
      tick_mode = 0;
      tick_period = 1;
      rst = 1'b0;
      a_valid = 1'b0; a_digit = 4'd0; a_color = 2'b00;
      b_valid = 1'b0; b_digit = 4'd0; b_color = 2'b00;

      test_reset();
      test_single();
      test_arbitration();
      test_fifo_full();
      test_back_to_back();
      test_blank_code();
      test_random();
      test_reset_mid_show();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
